// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared constants and types for the ID/EX pipeline register and its
//   load-use hazard detector.
//
//   Contents:
//     XLEN_DEFAULT   default datapath width
//     CTRL_W_DEFAULT default width of the opaque EX/MEM/WB control bundle
//     CNT_W_DEFAULT  default width of the load-use stall counter
//     REG_W          register index width
//     X0             hard-wired zero register index
//     OPC_*          major opcodes; OPC_LOAD is the one that drives
//                    id_mem_read in the decoder
//     is_load_opcode helper used by the decoder to produce id_mem_read
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int CTRL_W_DEFAULT = 12;
    localparam int CNT_W_DEFAULT  = 16;
    localparam int REG_W          = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Only the LOAD major opcode reads memory into a register, so it is the
    // only opcode that can create a load-use hazard.
    function automatic logic is_load_opcode(input logic [6:0] opcode);
        return (opcode == OPC_LOAD);
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard detector. Flags the case where the
//   instruction in EX is a load whose destination is a source of the
//   instruction currently in ID. Register x0 never creates a hazard.
//
//   Ports:
//     ex_valid     in  EX slot holds a real instruction
//     ex_mem_read  in  EX instruction is a load
//     ex_rd        in  EX destination index
//     id_valid     in  ID slot holds a real instruction
//     id_rs1       in  ID source index 1
//     id_rs2       in  ID source index 2
//     haz          out hazard present; insert one bubble
// ---------------------------------------------------------------------------
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    input  logic     id_valid,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    output logic     haz
);

    logic ex_is_load;
    logic src_match;

    assign ex_is_load = ex_valid & ex_mem_read & (ex_rd != X0);
    assign src_match  = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    assign haz        = ex_is_load & id_valid & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register sitting directly after the register file.
//   Captures decode outputs and register read data, inserts a single bubble
//   on a load-use hazard, honours branch flush (highest priority) and execute
//   back-pressure, and counts inserted bubbles with a saturating counter.
//
//   Optional feature macro: ID_EX_WB_BYPASS_EN
//     defined   : a writeback happening in the same cycle as the capture is
//                 forwarded into ex_dataA/ex_dataB (x0 is never forwarded).
//     undefined : operands come straight from id_dataA/id_dataB and the wb_*
//                 ports are ignored; the integration must make the register
//                 file write-before-read (negedge write) or add a stall.
//
//   Ports:
//     clk, reset                 clock (rising edge), async active-low reset
//     id_valid, id_pc            decode slot valid and PC
//     id_rs1, id_rs2, id_rd      source/destination indices
//     id_dataA, id_dataB         register file read data for rs1/rs2
//     id_imm, id_ctrl            immediate and control bundle
//     id_mem_read, id_reg_write  load flag and register-write flag
//     wb_write_enable/reg/data   writeback port (bypass source)
//     ex_flush                   kill the ID slot (taken branch in EX)
//     ex_stall                   execute cannot accept this cycle
//     ex_*                       registered EX-slot outputs
//     stall_if_id                combinational freeze for PC and IF/ID
//     stall_count                saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  reg_idx_t          id_rs1,
    input  reg_idx_t          id_rs2,
    input  reg_idx_t          id_rd,
    input  logic [XLEN-1:0]   id_dataA,
    input  logic [XLEN-1:0]   id_dataB,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,

    input  logic              wb_write_enable,
    input  reg_idx_t          wb_write_reg,
    input  logic [XLEN-1:0]   wb_write_data,

    input  logic              ex_flush,
    input  logic              ex_stall,

    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output reg_idx_t          ex_rs1,
    output reg_idx_t          ex_rs2,
    output reg_idx_t          ex_rd,
    output logic [XLEN-1:0]   ex_dataA,
    output logic [XLEN-1:0]   ex_dataB,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,

    output logic              stall_if_id,
    output logic [CNT_W-1:0]  stall_count
);

    // Counter holds at all-ones instead of wrapping so a long run of hazards
    // never reads back as a small number.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic            haz;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;

    // ---- ID stage: hazard detection and operand selection (combinational)
    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .haz         (haz)
    );

    // A flush discards whatever ID holds, so freezing the front end would
    // only delay the redirected fetch.
    assign stall_if_id = (haz | ex_stall) & ~ex_flush;

`ifdef ID_EX_WB_BYPASS_EN
    logic bypass_a;
    logic bypass_b;

    // The register file has not yet absorbed this cycle's writeback, so its
    // read data is stale for a matching source; take the writeback value.
    assign bypass_a  = wb_write_enable & (wb_write_reg != X0) & (wb_write_reg == id_rs1);
    assign bypass_b  = wb_write_enable & (wb_write_reg != X0) & (wb_write_reg == id_rs2);
    assign operand_a = bypass_a ? wb_write_data : id_dataA;
    assign operand_b = bypass_b ? wb_write_data : id_dataB;
`else
    logic unused_wb;

    assign operand_a = id_dataA;
    assign operand_b = id_dataB;
    assign unused_wb = ^{wb_write_enable, wb_write_reg, wb_write_data};
`endif

    // ---- ID/EX boundary register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1       <= X0;
            ex_rs2       <= X0;
            ex_rd        <= X0;
            ex_dataA     <= '0;
            ex_dataB     <= '0;
            ex_ctrl      <= '0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            stall_count  <= '0;
        end else if (ex_flush) begin
            // Only the side-effecting bits need clearing; data fields hold.
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (ex_stall) begin
            // Execute is busy: hold the whole slot, including a pending hazard.
        end else if (haz) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            stall_count  <= sat_inc(stall_count);
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_dataA     <= operand_a;
            ex_dataB     <= operand_b;
            ex_ctrl      <= id_ctrl;
            ex_mem_read  <= id_mem_read & id_valid;
            ex_reg_write <= id_reg_write & id_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN    = 32;
    localparam int CTRL_W  = 12;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    reg_idx_t          id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_dataA, id_dataB, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read, id_reg_write;
    logic              wb_write_enable;
    reg_idx_t          wb_write_reg;
    logic [XLEN-1:0]   wb_write_data;
    logic              ex_flush, ex_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_imm;
    reg_idx_t          ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]   ex_dataA, ex_dataB;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read, ex_reg_write;
    logic              stall_if_id;
    logic [CNT_W-1:0]  stall_count;

    int checks = 0;
    int errors = 0;

    // Reference view of the EX slot
    logic              m_valid, m_mr, m_rw;
    logic [XLEN-1:0]   m_pc, m_imm, m_a, m_b;
    reg_idx_t          m_rs1, m_rs2, m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_dataA(id_dataA), .id_dataB(id_dataB), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .wb_write_enable(wb_write_enable), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_flush(ex_flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_dataA(ex_dataA), .ex_dataB(ex_dataB), .ex_ctrl(ex_ctrl),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .stall_if_id(stall_if_id), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_haz();
        return m_valid && m_mr && (m_rd != 5'd0) && id_valid &&
               (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    function automatic logic model_stall();
        return (model_haz() || ex_stall) && !ex_flush;
    endfunction

    function automatic logic [XLEN-1:0] model_operand(input reg_idx_t rs, input logic [XLEN-1:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_write_enable && wb_write_reg != 5'd0 && wb_write_reg == rs)
            return wb_write_data;
`endif
        if (rs == 5'h1f && rf === 'x) return '0;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_mr = 0; m_rw = 0; m_pc = '0; m_imm = '0; m_a = '0; m_b = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic hz;
        hz = model_haz();
        if (ex_flush) begin
            m_valid = 0; m_mr = 0; m_rw = 0;
        end else if (ex_stall) begin
            m_valid = m_valid;
        end else if (hz) begin
            m_valid = 0; m_mr = 0; m_rw = 0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid; m_pc = id_pc; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_ctrl = id_ctrl;
            m_a = model_operand(id_rs1, id_dataA);
            m_b = model_operand(id_rs2, id_dataB);
            m_mr = id_mem_read && id_valid;
            m_rw = id_reg_write && id_valid;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(ex_valid), 64'(m_valid));
        chk({tag, ".pc"},    64'(ex_pc),    64'(m_pc));
        chk({tag, ".imm"},   64'(ex_imm),   64'(m_imm));
        chk({tag, ".rs1"},   64'(ex_rs1),   64'(m_rs1));
        chk({tag, ".rs2"},   64'(ex_rs2),   64'(m_rs2));
        chk({tag, ".rd"},    64'(ex_rd),    64'(m_rd));
        chk({tag, ".dataA"}, 64'(ex_dataA), 64'(m_a));
        chk({tag, ".dataB"}, 64'(ex_dataB), 64'(m_b));
        chk({tag, ".ctrl"},  64'(ex_ctrl),  64'(m_ctrl));
        chk({tag, ".mr"},    64'(ex_mem_read),  64'(m_mr));
        chk({tag, ".rw"},    64'(ex_reg_write), 64'(m_rw));
        chk({tag, ".cnt"},   64'(stall_count),  64'(m_cnt));
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic step(input string tag);
        #1;
        chk({tag, ".stall_if_id"}, 64'(stall_if_id), 64'(model_stall()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [XLEN-1:0] pc, input reg_idx_t rs1,
                          input reg_idx_t rs2, input reg_idx_t rd, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic mr, input logic rw);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_dataA = a; id_dataB = b; id_mem_read = mr; id_reg_write = rw;
        id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
    endtask

    initial begin
        logic [XLEN-1:0] exp_a;

        reset = 0;
        set_id(0, '0, '0, '0, '0, '0, '0, 0, 0);
        wb_write_enable = 0; wb_write_reg = '0; wb_write_data = '0;
        ex_flush = 0; ex_stall = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_outputs("rst");
        chk("rst.stall_if_id", 64'(stall_if_id), 64'(0));

        // Normal load
        reset = 1;
        set_id(1, 32'h100, 5'd1, 5'd2, 5'd5, 32'h1, 32'h22, 0, 1);
        step("load");
        chk("load.ex_pc", 64'(ex_pc), 64'h100);
        chk("load.ex_dataA", 64'(ex_dataA), 64'h1);
        chk("load.ex_valid", 64'(ex_valid), 64'h1);

        // Load-use: one bubble, then the dependent instruction loads
        set_id(1, 32'h104, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 1, 1);
        step("lu_load");
        set_id(1, 32'h108, 5'd4, 5'd3, 5'd6, 32'h44, 32'h33, 0, 1);
        #1 chk("lu.stall_hi", 64'(stall_if_id), 64'h1);
        step("lu_bubble");
        chk("lu.bubble_valid", 64'(ex_valid), 64'h0);
        chk("lu.stall_cnt", 64'(stall_count), 64'h1);
        #1 chk("lu.stall_lo", 64'(stall_if_id), 64'h0);
        step("lu_dep");
        chk("lu.dep_valid", 64'(ex_valid), 64'h1);
        chk("lu.dep_pc", 64'(ex_pc), 64'h108);

        // Load to x0 never stalls
        set_id(1, 32'h200, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1, 1);
        step("x0_load");
        set_id(1, 32'h204, 5'd0, 5'd9, 5'd8, 32'h0, 32'h9, 0, 1);
        #1 chk("x0.no_stall", 64'(stall_if_id), 64'h0);
        step("x0_dep");
        chk("x0.valid", 64'(ex_valid), 64'h1);

        // Writeback bypass
        wb_write_enable = 1; wb_write_reg = 5'd7; wb_write_data = 32'hDEADBEEF;
        set_id(1, 32'h300, 5'd7, 5'd1, 5'd2, 32'h7, 32'h11, 0, 1);
        step("wb_hit");
`ifdef ID_EX_WB_BYPASS_EN
        exp_a = 32'hDEADBEEF;
`else
        exp_a = 32'h7;
`endif
        chk("wb.dataA", 64'(ex_dataA), 64'(exp_a));
        wb_write_reg = 5'd0;
        set_id(1, 32'h304, 5'd0, 5'd1, 5'd2, 32'h7, 32'h11, 0, 1);
        step("wb_x0");
        chk("wb0.dataA", 64'(ex_dataA), 64'h7);
        wb_write_enable = 0;

        // Flush beats stall
        ex_flush = 1; ex_stall = 1;
        #1 chk("flush.stall_if_id", 64'(stall_if_id), 64'h0);
        step("flush");
        chk("flush.valid", 64'(ex_valid), 64'h0);
        ex_flush = 0; ex_stall = 0;

        // Counter saturation
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            set_id(1, 32'h400, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 1, 1);
            step("sat_load");
            set_id(1, 32'h404, 5'd2, 5'd0, 5'd3, 32'h5, 32'h0, 0, 1);
            step("sat_bubble");
        end
        chk("sat.cnt", 64'(stall_count), 64'(CNT_MAX));

        // Async reset mid-stall with a pending hazard
        set_id(1, 32'h500, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 1, 1);
        step("ar_load");
        set_id(1, 32'h504, 5'd3, 5'd0, 5'd4, 32'h0, 32'h0, 0, 1);
        ex_stall = 1;
        step("ar_hold");
        #2 reset = 0;
        model_reset();
        #1;
        chk("ar.valid", 64'(ex_valid), 64'h0);
        chk("ar.cnt", 64'(stall_count), 64'h0);
        chk("ar.stall_if_id", 64'(stall_if_id), 64'(ex_stall));
        check_outputs("ar");
        @(negedge clk);
        reset = 1; ex_stall = 0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            wb_write_enable = $urandom_range(0, 1) == 1;
            wb_write_reg = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            ex_flush = $urandom_range(0, 9) == 0;
            ex_stall = $urandom_range(0, 4) == 0;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file.
- Captures decode outputs and register-file read data, then presents them to the execute stage.
- Detects load-use hazards, inserts bubbles and applies branch flush and execute back-pressure.
- Bypasses a same-cycle writeback so that execute never sees stale register data.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 12, width of the opaque execute/memory/writeback control bundle.
- CNT_W, 16, width of the stall-event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  XLEN  decode PC.
- id_rs1, id_rs2  in  5  source register indices, also driven to the register file read ports.
- id_rd  in  5  destination register index.
- id_dataA, id_dataB  in  XLEN  register file read data for rs1/rs2.
- id_imm  in  XLEN  decoded immediate.
- id_ctrl  in  CTRL_W  control bundle.
- id_mem_read  in  1  instruction is a load.
- id_reg_write  in  1  instruction writes rd.
- wb_write_enable  in  1  writeback write strobe, same signal as the register file write_enable.
- wb_write_reg  in  5  writeback destination index.
- wb_write_data  in  XLEN  writeback data.
- ex_flush  in  1  taken branch/jump resolved in EX; kill the ID slot.
- ex_stall  in  1  execute cannot accept a new instruction this cycle.
- ex_valid  out  1  EX slot valid.
- ex_pc, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices.
- ex_dataA, ex_dataB  out  XLEN  registered operands, after bypass.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_mem_read, ex_reg_write  out  1  registered; forced to 0 in bubbles.
- stall_if_id  out  1  combinational; freeze PC and the IF/ID register.
- stall_count  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (reset=0, asynchronous) clears every output register to 0, including ex_valid, all data fields and stall_count.
- Hazard condition, combinational:
  - haz = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - stall_if_id = (haz | ex_stall) & ~ex_flush.
- Per-edge priority, highest first:
  1. ex_flush: ex_valid<=0, ex_mem_read<=0, ex_reg_write<=0; other fields don't-care but held.
  2. ex_stall: hold all EX registers unchanged.
  3. haz: bubble; ex_valid<=0, ex_mem_read<=0, ex_reg_write<=0; stall_count increments, saturating at all-ones.
  4. Otherwise: load all fields from the ID inputs; ex_valid<=id_valid, ex_mem_read<=id_mem_read&id_valid, ex_reg_write<=id_reg_write&id_valid.
- Operand selection at load:
  - ex_dataA = bypassA ? wb_write_data : id_dataA, where bypassA = wb_write_enable & (wb_write_reg!=0) & (wb_write_reg==id_rs1).
  - ex_dataB uses the same rule with id_rs2.
  - Index 0 is never bypassed, so x0 always reads 0.
- Latency: one cycle from ID inputs to EX outputs.
- A load-use hazard produces exactly one bubble. Afterwards ex_valid=0, so haz drops and the dependent instruction loads next cycle, with the load result supplied by EX forwarding.
- A hazard present while ex_stall=1 keeps holding; the bubble is inserted on the first cycle with ex_stall=0.
- Reset asserted mid-stall clears all state. stall_if_id then follows the combinational rule with ex_valid=0, so it equals ex_stall.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: same-cycle writeback bypass active, as described above.
- Undefined: ex_dataA/ex_dataB take id_dataA/id_dataB directly, and the wb_* ports are unused. In this configuration the register file must write on the negative edge, or an extra stall covers the case; the pipeline integration owns that choice.

Decomposition:
- Shared package: XLEN, register index width (5), CTRL_W, the X0 constant and the opcode constants that produce id_mem_read.
- One natural sub-module: load_use_detect. It is purely combinational (ex_* and id_* in, haz out) so the hazard unit can be reused and tested standalone.
- Bypass muxes and registers stay in id_ex_stage.

Test Plan:
- Reset and normal load:
  - Release reset; id_valid=1, id_pc=0x100, id_rs1=1, id_dataA=0x1, id_rd=5.
  - Next cycle: ex_valid=1, ex_pc=0x100, ex_dataA=0x1, stall_count=0.
- Load-use:
  - EX holds a load with rd=3; ID has rs2=3.
  - stall_if_id=1 for exactly one cycle, then ex_valid=0 (bubble) and stall_count=1.
  - The following cycle the dependent instruction loads with ex_valid=1.
- x0 load:
  - EX holds a load with rd=0; ID has rs1=0.
  - No stall and no bubble.
- WB bypass:
  - wb_write_enable=1, wb_write_reg=7, wb_write_data=0xDEADBEEF; id_rs1=7, id_dataA=0x7.
  - ex_dataA=0xDEADBEEF.
  - With wb_write_reg=0, ex_dataA follows id_dataA instead.
- Flush beats stall:
  - ex_flush=1 and ex_stall=1 in the same cycle.
  - Next cycle ex_valid=0; stall_if_id=0 during the flush cycle.
- Async reset mid-stall:
  - ex_stall=1 with haz active; drive reset=0 between clock edges.
  - ex_valid and stall_count go to 0 immediately; stall_if_id equals ex_stall.
